carry_ripple_adder: RTL and testbench
=====================================

# carry_ripple_adder

Registered WIDTH-bit ripple-carry adder, 32 bits by default. It is the arithmetic core of the byte-loaded 32-bit ALU controller. It adds operands A and B plus a carry-in through a chain of single-bit full-adder cells, then captures sum, carry-out and signed overflow in an output register. The controller slices the captured sum into bytes for display.

## Interface
- WIDTH, 32: operand and sum width in bits; legal range 1 to 64.

Ports (declaration order is a, b, cin, sum, cout, clk, rst, in_valid, out_valid, ovf, so the existing 5-port positional hookup stays valid):
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, asynchronous and active-high; clears all registered outputs.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- in_valid  input  1  operands are valid this cycle. When left unconnected it is tied to 1 by default.
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- out_valid  output  1  registered copy of in_valid.

## Operation
- Datapath is WIDTH full-adder cells chained bit 0 to bit WIDTH-1, using the generate form.
  - Cell i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = cin.
  - No carry-lookahead, no carry-select, no synthesis "+" operator on the full width. Structural rippling is required.
- Combinational results: s = {s_{WIDTH-1}..s_0}, co = c_WIDTH, ov = c_{WIDTH-1} ^ c_WIDTH.
- Output register:
  - On each rising clk with rst low, out_valid <= in_valid.
  - When in_valid = 1, sum <= s, cout <= co, ovf <= ov.
  - When in_valid = 0, sum, cout and ovf hold their previous values.
- Wrap-around:
  - All-ones + 0 + cin=1 gives sum 0, cout 1.
  - All-ones + all-ones + cin=1 gives sum all-ones, cout 1.
- Signed overflow is set only when A and B share a sign bit and the sum sign differs.
- There are no internal state machines. The register is the only state.

## Timing
- Latency is exactly 1 clock from operands and in_valid to sum, cout, ovf and out_valid. Throughput is one addition per clock.
- The critical path is the full WIDTH-bit carry chain, from cin or a_0/b_0 to c_WIDTH. Clock-period budgeting must allow WIDTH cell delays.
- Reset:
  - rst high forces sum = 0, cout = 0, ovf = 0, out_valid = 0 immediately, without waiting for clk.
  - These values hold while rst is high.
  - The first capture occurs on the first rising clk after rst falls.
- Reset asserted mid-operation discards the in-flight result. out_valid is 0 on the following cycle regardless of in_valid.
- Operand changes between clock edges have no effect on outputs until the next edge. Outputs are glitch-free.
- in_valid toggling every cycle causes out_valid to follow with 1-cycle delay. Held data persists across invalid cycles.

## Test plan
- Reset: drive rst=1 with a=0xFFFFFFFF, b=1, in_valid=1, toggling clk. Required: sum=0, cout=0, ovf=0, out_valid=0 throughout. Release rst; one edge later: sum=0x00000000, cout=1, ovf=0, out_valid=1.
- Basic add: a=0x12345678, b=0x11111111, cin=0 -> next edge sum=0x23456789, cout=0, ovf=0. Same operands with cin=1 -> sum=0x2345678A.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. Then a=b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
- Signed overflow:
  - a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1, cout=0.
  - a=0x80000000, b=0x80000000 -> sum=0, ovf=1, cout=1.
  - a=0xFFFFFFFF, b=1 -> ovf=0.
- Hold and latency: apply 0x00000005+0x00000003 with in_valid=1, then change operands to 0xAAAAAAAA+0x55555555 with in_valid=0. Required: sum stays 0x00000008 and out_valid drops to 0 one cycle later. Reassert in_valid -> sum=0xFFFFFFFF, cout=0 on the next edge.
- Random plus parameter sweep: 10,000 random a/b/cin vectors, checked against a reference model {cout,sum} = a + b + cin, one cycle delayed. Repeat with WIDTH=8 and WIDTH=1, including the 1+1+1 case -> sum=1, cout=1.

Source files
------------

// File: rtl/carry_ripple_adder.sv
// ---------------------------------------------------------------------------
// carry_ripple_adder
//
// Registered WIDTH-bit ripple-carry adder: the arithmetic core of the
// byte-loaded 32-bit ALU controller. Operands A and B and a carry-in pass
// through a chain of single-bit full-adder cells. The sum, carry-out and
// signed overflow are then captured in an output register.
//
// Parameters:
//   WIDTH      operand and sum width in bits (1 to 64), default 32
//
// Ports (order kept so the legacy 5-port positional hookup still works):
//   a          input  [WIDTH-1:0]  operand A (unsigned or two's complement)
//   b          input  [WIDTH-1:0]  operand B
//   cin        input               carry into bit 0
//   sum        output [WIDTH-1:0]  registered (a + b + cin) mod 2^WIDTH
//   cout       output              registered carry out of bit WIDTH-1
//   clk        input               rising-edge clock
//   rst        input               asynchronous active-high reset
//   in_valid   input               operands valid this cycle (defaults to 1)
//   out_valid  output              registered copy of in_valid
//   ovf        output              registered signed overflow
// ---------------------------------------------------------------------------
module carry_ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid = 1'b1,
  output logic             out_valid,
  output logic             ovf
);

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the top cell.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  assign carry[0] = cin;

  // One full-adder cell per bit, chained from bit 0 upward. The carry is
  // kept structural on purpose so the chain stays a true ripple. It does
  // not collapse into a wide adder operator.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      logic half;
      assign half         = a[i] ^ b[i];
      assign s[i]         = half ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & half);
    end
  endgenerate

  // Signed overflow is the carry into the MSB disagreeing with the carry
  // out of it. When WIDTH is 1, the carry into the MSB is cin itself.
  assign co = carry[WIDTH];
  assign ov = carry[WIDTH-1] ^ carry[WIDTH];

  // Output register. out_valid follows in_valid on every edge. The result
  // fields only load on valid cycles, so the last real result is held
  // across idle cycles for the controller's byte display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= co;
        ovf  <= ov;
      end
    end
  end

endmodule

// File: tb/tb_carry_ripple_adder.sv
// ---------------------------------------------------------------------------
// tb_carry_ripple_adder
//
// Self-checking bench for carry_ripple_adder at WIDTH = 32, 8 and 1.
// A table of directed vectors drives the 32-bit instance. Hand-written
// sequences cover reset and the release from reset. Randomized vectors
// drive all three widths, and each result is compared with an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_carry_ripple_adder;

  logic clk;
  logic rst;

  logic [31:0] a32, b32, sum32;
  logic        cin32, iv32, cout32, ovf32, ov32;

  logic [7:0]  a8, b8, sum8;
  logic        cin8, iv8, cout8, ovf8, ov8;

  logic [0:0]  a1, b1, sum1;
  logic        cin1, iv1, cout1, ovf1, ov1;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        in_valid;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[10];

  carry_ripple_adder #(.WIDTH(32)) dut32 (
    .a(a32), .b(b32), .cin(cin32), .sum(sum32), .cout(cout32),
    .clk(clk), .rst(rst), .in_valid(iv32), .out_valid(ov32), .ovf(ovf32)
  );

  carry_ripple_adder #(.WIDTH(8)) dut8 (
    .a(a8), .b(b8), .cin(cin8), .sum(sum8), .cout(cout8),
    .clk(clk), .rst(rst), .in_valid(iv8), .out_valid(ov8), .ovf(ovf8)
  );

  carry_ripple_adder #(.WIDTH(1)) dut1 (
    .a(a1), .b(b1), .cin(cin1), .sum(sum1), .cout(cout1),
    .clk(clk), .rst(rst), .in_valid(iv1), .out_valid(ov1), .ovf(ovf1)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It adds the operands in wide integer arithmetic and
  // reads carry and overflow from the sign-bit rule.
  function automatic void model(input int w, input logic [63:0] a,
                                input logic [63:0] b, input logic cin,
                                output logic [63:0] s, output logic co,
                                output logic ov);
    logic [64:0] mask;
    logic [64:0] total;
    mask  = (65'd1 << w) - 65'd1;
    total = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, cin};
    s     = total[63:0] & mask[63:0];
    co    = total[w];
    ov    = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drives the 32-bit operands, then waits until just after the next
  // rising edge so the registered outputs can be sampled.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic iv);
    a32   = a;
    b32   = b;
    cin32 = cin;
    iv32  = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] s,
                         input logic co, input logic ov, input logic v);
    checkOutput({name, ".sum"},       {32'd0, sum32}, {32'd0, s});
    checkOutput({name, ".cout"},      {63'd0, cout32}, {63'd0, co});
    checkOutput({name, ".ovf"},       {63'd0, ovf32}, {63'd0, ov});
    checkOutput({name, ".out_valid"}, {63'd0, ov32}, {63'd0, v});
  endtask

  initial begin
    logic [63:0] es32, es8, es1, ts;
    logic        ec32, ec8, ec1, eo32, eo8, eo1, tc, to;
    logic        ev32, ev8, ev1;
    logic [31:0] ra, rb;
    logic [2:0]  rc;
    logic [2:0]  riv;

    vecs[0] = '{"add",      32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"add_cin",  32'h12345678, 32'h11111111, 1'b1, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"ripple0",  32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"ripple1",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"ovf_pos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{"ovf_neg",  32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{"no_ovf",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"hold_ld",  32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{"hold",     32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"hold_rel", 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};

    // The narrow instances stay idle until the random phase.
    a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0; iv1 = 1'b0;

    // Reset phase: the operands are live, but every output must stay cleared.
    rst   = 1'b1;
    a32   = 32'hFFFFFFFF;
    b32   = 32'h00000001;
    cin32 = 1'b0;
    iv32  = 1'b1;
    #1;
    check32("rst_t0", 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check32("rst_hold", 32'h0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("rst_rel", 32'h0, 1'b1, 1'b0, 1'b1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].in_valid);
      check32(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout,
              vecs[i].exp_ovf, vecs[i].exp_valid);
    end

    // Mid-operation reset clears the outputs at once, between edges.
    #2;
    rst = 1'b1;
    #1;
    check32("midrst_async", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check32("midrst_edge", 32'h0, 1'b0, 1'b0, 1'b0);
    a32 = 32'hFFFFFFFF; b32 = 32'h00000001; cin32 = 1'b0; iv32 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("midrst_rel", 32'h0, 1'b1, 1'b0, 1'b1);

    // Directed 1-bit corner case: 1 + 1 + 1.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("w1_111.sum",  {63'd0, sum1},  64'd1);
    checkOutput("w1_111.cout", {63'd0, cout1}, 64'd1);
    checkOutput("w1_111.ovf",  {63'd0, ovf1},  64'd0);

    // Random phase. The model holds the last valid result for each width.
    es32 = {32'd0, sum32}; ec32 = cout32; eo32 = ovf32;
    es8  = {56'd0, sum8};  ec8  = cout8;  eo8  = ovf8;
    es1  = 64'd1;          ec1  = 1'b1;   eo1  = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      ra  = $urandom;
      rb  = $urandom;
      rc  = 3'($urandom);
      riv = 3'($urandom);
      a32 = ra;        b32 = rb;        cin32 = rc[0]; iv32 = (riv[0] | riv[1]);
      a8  = ra[15:8];  b8  = rb[15:8];  cin8  = rc[1]; iv8  = (riv[1] | riv[2]);
      a1  = ra[20];    b1  = rb[20];    cin1  = rc[2]; iv1  = (riv[2] | riv[0]);
      ev32 = iv32; ev8 = iv8; ev1 = iv1;
      if (iv32) begin
        model(32, {32'd0, a32}, {32'd0, b32}, cin32, ts, tc, to);
        es32 = ts; ec32 = tc; eo32 = to;
      end
      if (iv8) begin
        model(8, {56'd0, a8}, {56'd0, b8}, cin8, ts, tc, to);
        es8 = ts; ec8 = tc; eo8 = to;
      end
      if (iv1) begin
        model(1, {63'd0, a1}, {63'd0, b1}, cin1, ts, tc, to);
        es1 = ts; ec1 = tc; eo1 = to;
      end
      @(posedge clk);
      #1;
      checkOutput("r32.sum",  {32'd0, sum32}, es32);
      checkOutput("r32.cout", {63'd0, cout32}, {63'd0, ec32});
      checkOutput("r32.ovf",  {63'd0, ovf32}, {63'd0, eo32});
      checkOutput("r32.vld",  {63'd0, ov32},  {63'd0, ev32});
      checkOutput("r8.sum",   {56'd0, sum8},  es8);
      checkOutput("r8.cout",  {63'd0, cout8}, {63'd0, ec8});
      checkOutput("r8.ovf",   {63'd0, ovf8},  {63'd0, eo8});
      checkOutput("r8.vld",   {63'd0, ov8},   {63'd0, ev8});
      checkOutput("r1.sum",   {63'd0, sum1},  es1);
      checkOutput("r1.cout",  {63'd0, cout1}, {63'd0, ec1});
      checkOutput("r1.ovf",   {63'd0, ovf1},  {63'd0, eo1});
      checkOutput("r1.vld",   {63'd0, ov1},   {63'd0, ev1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
